// File: rtl/fwd_hazard_if.sv
// Hazard-unit bus: ID-stage instruction fields in; EX bypass selects, ID stall and
// performance counters out. master = pipeline control, slave = fwd_hazard_scoreboard.
interface fwd_hazard_if #(
  parameter int RA_W  = 5,
  parameter int SEL_W = 3
);
  // id_valid qualifies the id_* fields in the cycle they are presented; there is no ready.
  // stall is the back-pressure: while stall=1 the ID instruction is not taken and must be held.
  logic             id_valid;
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic [RA_W-1:0]  id_rd;
  logic             id_regwrite;
  logic             id_is_load;
  logic             flush;
  logic [SEL_W-1:0] fwd_sel1;
  logic [SEL_W-1:0] fwd_sel2;
  logic             stall;
  logic [31:0]      stall_cnt;
  logic [31:0]      fwd_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_is_load, flush,
    input  fwd_sel1, fwd_sel2, stall, stall_cnt, fwd_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_is_load, flush,
    output fwd_sel1, fwd_sel2, stall, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding / load-use hazard unit tracking DEPTH in-flight stages past ID (entry 1 = EX).
// Optional macro HAZ_PERF_CNT_EN adds stall and bypass event counters.
module fwd_hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int LD_STAGE = 3,
  parameter int RA_W     = 5,
  parameter int SEL_W    = 3
) (
  input logic         clk,
  input logic         rst,
  fwd_hazard_if.slave hz
);
  logic             v_q  [1:DEPTH];
  logic             v_d  [1:DEPTH];
  logic             wr_q [1:DEPTH];
  logic             wr_d [1:DEPTH];
  logic             ld_q [1:DEPTH];
  logic             ld_d [1:DEPTH];
  logic [RA_W-1:0]  rd_q [1:DEPTH];
  logic [RA_W-1:0]  rd_d [1:DEPTH];
  logic [RA_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
  logic [SEL_W-1:0] sel1, sel2;
  logic             found1, found2, hit1, hit2, need1, need2;
  logic             stall, issue;

  // Youngest producer in stages 2..DEPTH wins; a load not yet at LD_STAGE cannot bypass.
  always_comb begin : fwd_select
    sel1   = '0;
    sel2   = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    for (int k = 2; k <= DEPTH; k++) begin
      if (!found1 && v_q[k] && wr_q[k] && rs1_q != '0 && rd_q[k] == rs1_q) begin
        found1 = 1'b1;
        sel1   = (ld_q[k] && k < LD_STAGE) ? '0 : SEL_W'(k);
      end
      if (!found2 && v_q[k] && wr_q[k] && rs2_q != '0 && rd_q[k] == rs2_q) begin
        found2 = 1'b1;
        sel2   = (ld_q[k] && k < LD_STAGE) ? '0 : SEL_W'(k);
      end
    end
    if (!v_q[1]) begin
      sel1 = '0;
      sel2 = '0;
    end
  end

  // Stall while the youngest producer of an ID source is a load that will still be
  // short of LD_STAGE when the ID instruction reaches EX next cycle.
  always_comb begin : load_use
    hit1  = 1'b0;
    hit2  = 1'b0;
    need1 = 1'b0;
    need2 = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (!hit1 && v_q[k] && wr_q[k] && hz.id_rs1 != '0 && rd_q[k] == hz.id_rs1) begin
        hit1  = 1'b1;
        need1 = ld_q[k] && (k + 1 < LD_STAGE);
      end
      if (!hit2 && v_q[k] && wr_q[k] && hz.id_rs2 != '0 && rd_q[k] == hz.id_rs2) begin
        hit2  = 1'b1;
        need2 = ld_q[k] && (k + 1 < LD_STAGE);
      end
    end
    stall = hz.id_valid && !hz.flush && (need1 || need2);
  end

  always_comb begin : next_table
    issue = hz.id_valid && !stall && !hz.flush;
    for (int k = 2; k <= DEPTH; k++) begin
      v_d[k]  = v_q[k-1];
      wr_d[k] = wr_q[k-1];
      ld_d[k] = ld_q[k-1];
      rd_d[k] = rd_q[k-1];
    end
    v_d[1]  = issue;
    wr_d[1] = issue && hz.id_regwrite;
    ld_d[1] = issue && hz.id_is_load;
    rd_d[1] = issue ? hz.id_rd  : '0;
    rs1_d   = issue ? hz.id_rs1 : '0;
    rs2_d   = issue ? hz.id_rs2 : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        v_q[k]  <= 1'b0;
        wr_q[k] <= 1'b0;
        ld_q[k] <= 1'b0;
        rd_q[k] <= '0;
      end
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        v_q[k]  <= v_d[k];
        wr_q[k] <= wr_d[k];
        ld_q[k] <= ld_d[k];
        rd_q[k] <= rd_d[k];
      end
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end

  assign hz.fwd_sel1 = sel1;
  assign hz.fwd_sel2 = sel2;
  assign hz.stall    = stall;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

  always_comb begin : perf_next
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    fwd_cnt_d   = fwd_cnt_q + {31'd0, |sel1} + {31'd0, |sel2};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.fwd_cnt   = fwd_cnt_q;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.fwd_cnt   = 32'd0;
`endif
endmodule
